// File: rtl/sync_filter_edge.sv
// Multi-channel input conditioner: enabled synchronizer chain, consecutive-cycle
// debounce filter and registered rise/fall pulse detection, one slice per channel.
module sync_filter_edge #(
  parameter int   BUS_WIDTH   = 1,
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] en,
  input  logic [BUS_WIDTH-1:0] async_in,
  output logic [BUS_WIDTH-1:0] sync_out,
  output logic [BUS_WIDTH-1:0] filt_out,
  output logic [BUS_WIDTH-1:0] rise,
  output logic [BUS_WIDTH-1:0] fall
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FILT_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sync_filter_edge: SYNC_STAGES must be >= 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("sync_filter_edge: FILT_CYCLES must be >= 1");
  end

  for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{RESET_VAL}};
      end else if (en[gi]) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], async_in[gi]};
      end
    end

    // Pulses default low every cycle, so they self-clear even while disabled.
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (en[gi]) begin
        if (sync_bit == filt_q) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d  = '0;
          filt_d = sync_bit;
          rise_d = sync_bit;
          fall_d = ~sync_bit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        filt_q <= RESET_VAL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
      end
    end

    assign sync_out[gi] = sync_bit;
    assign filt_out[gi] = filt_q;
    assign rise[gi]     = rise_q;
    assign fall[gi]     = fall_q;
  end

endmodule

// File: tb/tb_sync_filter_edge.sv
// Directed bench for sync_filter_edge: 4 channels, 3 sync stages, 4-cycle filter,
// plus a RESET_VAL=1 instance for the inverted-reset scenario.
module tb_sync_filter_edge;
  logic       clk = 1'b0;
  logic       rst_n, rst1_n;
  logic [3:0] en, en1, async_in, async1;
  logic [3:0] sync_out, filt_out, rise, fall;
  logic [3:0] sync1, filt1, rise1, fall1;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  sync_filter_edge #(.BUS_WIDTH(4), .SYNC_STAGES(3), .FILT_CYCLES(4), .RESET_VAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .async_in(async_in),
    .sync_out(sync_out), .filt_out(filt_out), .rise(rise), .fall(fall)
  );

  sync_filter_edge #(.BUS_WIDTH(4), .SYNC_STAGES(3), .FILT_CYCLES(4), .RESET_VAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1), .async_in(async1),
    .sync_out(sync1), .filt_out(filt1), .rise(rise1), .fall(fall1)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    en = 4'hF; en1 = 4'hF;
    async_in = 4'hF; async1 = 4'h0;

    // 1: reset values, then 3-edge sync latency and 7-edge filter latency
    tick(2);
    chk("t1_rst_sync", sync_out, 4'h0);
    chk("t1_rst_filt", filt_out, 4'h0);
    chk("t1_rst_rise", rise, 4'h0);
    chk("t1_rst_fall", fall, 4'h0);
    rst_n = 1'b1;
    tick(2);
    chk("t1_e2_sync", sync_out, 4'h0);
    tick(1);
    chk("t1_e3_sync", sync_out, 4'hF);
    chk("t1_e3_filt", filt_out, 4'h0);
    tick(3);
    chk("t1_e6_filt", filt_out, 4'h0);
    chk("t1_e6_rise", rise, 4'h0);
    tick(1);
    chk("t1_e7_filt", filt_out, 4'hF);
    chk("t1_e7_rise", rise, 4'hF);
    chk("t1_e7_fall", fall, 4'h0);
    tick(1);
    chk("t1_e8_rise", rise, 4'h0);
    chk("t1_e8_filt", filt_out, 4'hF);

    // back to all-low
    async_in = 4'h0;
    tick(7);
    chk("t1b_filt", filt_out, 4'h0);
    chk("t1b_fall", fall, 4'hF);
    chk("t1b_rise", rise, 4'h0);
    tick(1);
    chk("t1b_fall_clr", fall, 4'h0);

    // 2: 3-cycle glitch on ch0 is rejected by the filter
    async_in = 4'b0001;
    tick(3);
    chk("t2_e3_sync", sync_out, 4'b0001);
    async_in = 4'b0000;
    for (int k = 4; k <= 10; k++) begin
      tick(1);
      chk($sformatf("t2_e%0d_sync", k), sync_out, (k <= 5) ? 4'b0001 : 4'b0000);
      chk($sformatf("t2_e%0d_filt", k), filt_out, 4'h0);
      chk($sformatf("t2_e%0d_rf", k), rise | fall, 4'h0);
    end

    // 3: ch1 held by en for 5 edges (async toggles meanwhile); ch3 runs freely
    async_in = 4'b1010;
    tick(5);
    chk("t3_e5_sync", sync_out, 4'b1010);
    chk("t3_e5_filt", filt_out, 4'b0000);
    en = 4'b1101;
    async_in = 4'b1000;
    tick(2);
    chk("t3_e7_filt", filt_out, 4'b1000);
    chk("t3_e7_rise", rise, 4'b1000);
    chk("t3_e7_sync", sync_out, 4'b1010);
    tick(3);
    chk("t3_e10_filt", filt_out, 4'b1000);
    chk("t3_e10_sync", sync_out, 4'b1010);
    async_in = 4'b1010;
    en = 4'hF;
    tick(1);
    chk("t3_e11_filt", filt_out, 4'b1000);
    chk("t3_e11_rise", rise, 4'b0000);
    tick(1);
    chk("t3_e12_filt", filt_out, 4'b1010);
    chk("t3_e12_rise", rise, 4'b0010);
    tick(1);
    chk("t3_e13_rise", rise, 4'b0000);

    // 4: reach filt=0011, then switch every channel at once to 1100
    async_in = 4'b0011;
    tick(7);
    chk("t4a_filt", filt_out, 4'b0011);
    chk("t4a_rise", rise, 4'b0001);
    chk("t4a_fall", fall, 4'b1000);
    tick(1);
    async_in = 4'b1100;
    tick(6);
    chk("t4_e6_filt", filt_out, 4'b0011);
    tick(1);
    chk("t4_e7_filt", filt_out, 4'b1100);
    chk("t4_e7_rise", rise, 4'b1100);
    chk("t4_e7_fall", fall, 4'b0011);
    tick(1);
    chk("t4_e8_rise", rise, 4'b0000);
    chk("t4_e8_fall", fall, 4'b0000);

    // 5: reset while ch2 is mid-count, then full latency again
    async_in = 4'b0000;
    tick(7);
    chk("t5a_filt", filt_out, 4'b0000);
    chk("t5a_fall", fall, 4'b1100);
    async_in = 4'b0100;
    tick(5);
    chk("t5_e5_sync", sync_out, 4'b0100);
    chk("t5_e5_filt", filt_out, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk("t5_arst_sync", sync_out, 4'b0000);
    chk("t5_arst_filt", filt_out, 4'b0000);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("t5_r3_sync", sync_out, 4'b0100);
    tick(3);
    chk("t5_r6_filt", filt_out, 4'b0000);
    tick(1);
    chk("t5_r7_filt", filt_out, 4'b0100);
    chk("t5_r7_rise", rise, 4'b0100);

    // 6: RESET_VAL=1 instance released with all-low input; reset kills the fall pulse
    chk("t6_rst_sync", sync1, 4'hF);
    chk("t6_rst_filt", filt1, 4'hF);
    chk("t6_rst_rf", rise1 | fall1, 4'h0);
    rst1_n = 1'b1;
    tick(3);
    chk("t6_e3_sync", sync1, 4'h0);
    chk("t6_e3_filt", filt1, 4'hF);
    tick(3);
    chk("t6_e6_filt", filt1, 4'hF);
    tick(1);
    chk("t6_e7_filt", filt1, 4'h0);
    chk("t6_e7_fall", fall1, 4'hF);
    chk("t6_e7_rise", rise1, 4'h0);
    rst1_n = 1'b0;
    #1;
    chk("t6_arst_fall", fall1, 4'h0);
    chk("t6_arst_filt", filt1, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
